// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit seven-segment controller: shadow register, scanned anodes,
// dead-time anti-ghosting, leading-zero blanking and selectable output polarity.
module seg7_scan #(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 1000,
    parameter int DEAD_CYCLES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                      m_clock,
    input  logic                      p_reset,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      load,
    input  logic                      lzb,
    input  logic                      enable,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [2:0]                digit_idx,
    output logic                      frame_tick
);

    localparam int                     CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]       DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [2:0]             IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]             SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0]  AN_OFF    = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    typedef enum logic [1:0] {IDLE, DARK, LIT} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [2:0]                idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0]   shadow_data;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic                      frame_tick_nxt;
    logic [7:0]                seg_act;
    logic [NUM_DIGITS-1:0]     an_act;
    logic [2:0]                digit_idx_nxt;
    logic [3:0]                nib;
    logic                      dp_sel;
    logic                      nonzero_above;
    logic                      blank;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
            4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h27;
            4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
            4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
        endcase
    endfunction

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        frame_tick_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt      = DARK;
                    cnt_nxt        = '0;
                    idx_nxt        = '0;
                    frame_tick_nxt = 1'b1;
                end
                DARK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == DEAD_LAST) state_nxt = LIT;
                end
                LIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DARK;
                        if (idx == IDX_LAST) begin
                            idx_nxt        = '0;
                            frame_tick_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so seg and anode land on the same edge as the slot change.
    always_comb begin
        nib           = 4'h0;
        dp_sel        = 1'b0;
        nonzero_above = 1'b0;
        an_act        = '0;
        seg_act       = 8'h00;
        digit_idx_nxt = 3'd0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (3'(j) == idx_nxt) begin
                nib    = shadow_data[4*j +: 4];
                dp_sel = shadow_dp[j];
                an_act[j] = (state_nxt == LIT);
            end
            if (3'(j) >= idx_nxt && shadow_data[4*j +: 4] != 4'h0) nonzero_above = 1'b1;
        end
        blank = lzb && (idx_nxt != 3'd0) && !nonzero_above;
        if (state_nxt == LIT) begin
            seg_act       = {dp_sel, blank ? 7'h00 : font(nib)};
            digit_idx_nxt = idx_nxt;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            seg         <= SEG_OFF;
            anode       <= AN_OFF;
            digit_idx   <= 3'd0;
            frame_tick  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            seg        <= seg_act ^ SEG_OFF;
            anode      <= an_act ^ AN_OFF;
            digit_idx  <= digit_idx_nxt;
            frame_tick <= frame_tick_nxt;
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp;
            end
        end
    end

endmodule
